// File: rtl/yasac_btn_in.sv
// yasac_btn_in: button input peripheral for the YASAC processor.
// Four push buttons are synchronised, debounced and turned into sticky
// press flags. Button 0 also drives an 8-bit press counter. The processor
// reads flags/levels on port09 and the counter on port10, and clears
// events through port07.
//
// Software handshake (level based, no strobes):
//   The program polls in_port until flag bit 4+i is 1, then writes ack bit i
//   high and back to 0. The flag is cleared on every edge where ack[i] is
//   sampled high. A press event landing on the same edge as ack[i] wins, so
//   an event is never lost. ack[7] clears the press counter in the same way.
//   A press on the clearing edge leaves the counter at 1.
module yasac_btn_in #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic [7:0] ack,
    output logic [7:0] in_port,
    output logic [7:0] count_port
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       db;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       flag;
    logic [7:0]       press_cnt;

    logic [3:0]       accept;
    logic [3:0]       press;

    // ack[6:4] have no function.
    logic             unused_ack;
    assign unused_ack = ^ack[6:4];

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // A new level is accepted once it has persisted for DEBOUNCE_CYCLES
    // mismatch edges; a press is an accepted 0->1 change.
    always_comb begin
        accept = 4'b0000;
        press  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            accept[i] = (s2[i] != db[i]) && (cnt[i] == CNT_LAST);
            press[i]  = accept[i] && s2[i];
        end
    end

    // Per-button debounce: stable level plus mismatch counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Sticky press flags; a press on the ack edge keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag <= 4'b0000;
        end else begin
            flag <= press | (flag & ~ack[3:0]);
        end
    end

    // Button-0 press counter, wraps 255->0; clear with press yields 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt <= 8'd0;
        end else if (ack[7]) begin
            press_cnt <= press[0] ? 8'd1 : 8'd0;
        end else if (press[0]) begin
            press_cnt <= press_cnt + 8'd1;
        end
    end

    assign in_port    = {flag, db};
    assign count_port = press_cnt;

endmodule

// File: tb/tb_yasac_btn_in.sv
// Testbench for yasac_btn_in with DEBOUNCE_CYCLES = 4 and a 20 ns clock.
// Inputs are driven on the falling edge; outputs are sampled on the next
// falling edge. Expected {count_port, in_port} values go to exp_q as the
// stimulus is driven, and each test drains and compares its own results.
module tb_yasac_btn_in;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn = 4'h0;
    logic [7:0] ack = 8'h00;
    logic [7:0] in_port;
    logic [7:0] count_port;

    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];

    int checks = 0;
    int errors = 0;

    // Reference state: press counter and press flags as the bench expects them.
    logic [7:0] m_cnt = 8'd0;
    logic [3:0] m_flag = 4'h0;

    yasac_btn_in #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .ack        (ack),
        .in_port    (in_port),
        .count_port (count_port)
    );

    // Clock generation.
    always #10 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #1ms;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    // Driver: apply one cycle of inputs, record expectation and observation.
    task automatic cyc(input logic [3:0] b, input logic [7:0] a, input logic [15:0] e);
        btn = b;
        ack = a;
        exp_q.push_back(e);
        @(negedge clk);
        obs_q.push_back({count_port, in_port});
    endtask

    // Driver: one full button-0 press and release; ack value a is applied on
    // the edge where the press is accepted (6th edge after the pad change).
    task automatic press0(input logic [7:0] a);
        for (int k = 0; k < 5; k++) cyc(4'h1, 8'h00, {m_cnt, m_flag, 4'h0});
        m_cnt     = a[7] ? 8'd1 : m_cnt + 8'd1;
        m_flag[0] = 1'b1;
        cyc(4'h1, a, {m_cnt, m_flag, 4'h1});
        for (int k = 0; k < 5; k++) cyc(4'h0, 8'h00, {m_cnt, m_flag, 4'h1});
        cyc(4'h0, 8'h00, {m_cnt, m_flag, 4'h0});
    endtask

    // Return to idle: buttons released and debounced, all events cleared.
    task automatic settle();
        btn = 4'h0;
        ack = 8'h00;
        repeat (8) @(negedge clk);
        ack = 8'h8F;
        @(negedge clk);
        ack = 8'h00;
        @(negedge clk);
        m_cnt  = 8'd0;
        m_flag = 4'h0;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        logic [15:0] o;
        int n;
        repeat (2) @(negedge clk);
        checks++;
        if ({count_port, in_port} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_initial got %h exp %h", {count_port, in_port}, 16'h0000);
        end
        reset = 1'b1;
        for (int k = 0; k < 5; k++) cyc(4'h1, 8'h00, 16'h0000);
        cyc(4'h1, 8'h00, 16'h0111);
        // Asynchronous reset pulse in the middle of the high phase.
        @(posedge clk);
        #5;
        reset = 1'b0;
        #1;
        checks++;
        if ({count_port, in_port} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", {count_port, in_port}, 16'h0000);
        end
        @(negedge clk);
        reset = 1'b1;
        // Button still held: full debounce and a fresh press event.
        for (int k = 0; k < 5; k++) cyc(4'h1, 8'h00, 16'h0000);
        cyc(4'h1, 8'h00, 16'h0111);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset idx %0d got %h exp %h", n, o, e);
            end
            n++;
        end
        m_cnt  = 8'd1;
        m_flag = 4'h1;
        settle();
    endtask

    task automatic test_clean_press();
        logic [15:0] e;
        logic [15:0] o;
        int n;
        press0(8'h00);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clean_press idx %0d got %h exp %h", n, o, e);
            end
            n++;
        end
        settle();
    endtask

    task automatic test_bounce();
        logic [15:0] e;
        logic [15:0] o;
        int n;
        for (int w = 1; w <= 3; w++) begin
            for (int k = 0; k < w; k++) cyc(4'h4, 8'h00, 16'h0000);
            for (int k = 0; k < 6; k++) cyc(4'h0, 8'h00, 16'h0000);
        end
        for (int k = 0; k < 4; k++) cyc(4'h4, 8'h00, 16'h0000);
        cyc(4'h0, 8'h00, 16'h0000);
        for (int k = 0; k < 4; k++) cyc(4'h0, 8'h00, 16'h0044);
        for (int k = 0; k < 3; k++) cyc(4'h0, 8'h00, 16'h0040);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bounce idx %0d got %h exp %h", n, o, e);
            end
            n++;
        end
        settle();
    endtask

    task automatic test_ack_collision();
        logic [15:0] e;
        logic [15:0] o;
        int n;
        for (int k = 0; k < 5; k++) cyc(4'h2, 8'h00, 16'h0000);
        cyc(4'h2, 8'h00, 16'h0022);
        cyc(4'h2, 8'h02, 16'h0002);
        cyc(4'h2, 8'h00, 16'h0002);
        for (int k = 0; k < 5; k++) cyc(4'h0, 8'h00, 16'h0002);
        cyc(4'h0, 8'h00, 16'h0000);
        // Press accepted on the same edge as ack[1].
        for (int k = 0; k < 5; k++) cyc(4'h2, 8'h00, 16'h0000);
        cyc(4'h2, 8'h02, 16'h0022);
        cyc(4'h2, 8'h00, 16'h0022);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ack_collision idx %0d got %h exp %h", n, o, e);
            end
            n++;
        end
        settle();
    endtask

    task automatic test_counter();
        logic [15:0] e;
        logic [15:0] o;
        int n;
        for (int p = 0; p < 256; p++) press0(8'h00);
        checks++;
        if (count_port !== 8'h00) begin
            errors++;
            $display("FAIL counter_wrap got %h exp %h", count_port, 8'h00);
        end
        for (int p = 0; p < 3; p++) press0(8'h00);
        press0(8'h80);
        m_cnt = 8'd0;
        cyc(4'h0, 8'h80, {m_cnt, m_flag, 4'h0});
        cyc(4'h0, 8'h00, {m_cnt, m_flag, 4'h0});
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL counter idx %0d got %h exp %h", n, o, e);
            end
            n++;
        end
        settle();
    endtask

    task automatic test_simultaneous();
        logic [15:0] e;
        logic [15:0] o;
        int n;
        for (int k = 0; k < 5; k++) cyc(4'hF, 8'h00, 16'h0000);
        cyc(4'hF, 8'h00, 16'h01FF);
        cyc(4'hF, 8'h0F, 16'h010F);
        cyc(4'hF, 8'h00, 16'h010F);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simultaneous idx %0d got %h exp %h", n, o, e);
            end
            n++;
        end
        settle();
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ack_collision();
        test_counter();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yasac_btn_in.md
# yasac_btn_in

Input-side peripheral for the YASAC processor. It synchronises and debounces four push buttons and records press events in sticky flags, presenting the result on the processor input port wired to `port09`. It also keeps an 8-bit press counter for button 0, wired to `port10`. The processor acknowledges and clears events through an output port (`port07`), which gives a level-based software handshake without bus strobes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive cycles a new level must persist before it is accepted. Legal range is 2 to 2^24.

Ports:
- `clk`  input  1: clock, rising edge.
- `reset`  input  1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Release is clean with respect to `clk`.
- `btn`  input  4: raw button pads, 1 = pressed. Asynchronous to `clk`.
- `ack`  input  8: driven from `port07`.
  - Bits [3:0]: clear the press flag of the corresponding button.
  - Bit 7: clear the press counter.
  - Bits [6:4]: ignored.
- `in_port`  output  8: drives `port09`.
  - Bits [3:0]: debounced levels.
  - Bits [7:4]: press flags for buttons 3..0.
- `count_port`  output  8: drives `port10`; press counter for button 0.

## Operation
- **Synchroniser:** each `btn[i]` passes through two flip-flops, `s1` then `s2`.
- **Debouncer** (per button): stable level `db[i]` plus counter `cnt[i]`, sized ceil(log2(DEBOUNCE_CYCLES)) bits.
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles resets the count and never reaches `db`.
- **Press event:** `db[i]` rising (0 to 1) in a cycle. Releases produce no event.
- **Flags** `flag[i]`:
  - Set on a press event; cleared in any cycle where `ack[i]` = 1.
  - If a press event and `ack[i]` = 1 occur in the same cycle, set wins and the flag stays 1.
  - Flags are sticky: repeated presses while a flag is set do not queue.
- **Press counter** (8 bits, button 0 only):
  - Increments on each button-0 press event and wraps 255 to 0.
  - `ack[7]` = 1 clears it.
  - If clear and increment occur in the same cycle, the result is 1.
- **Output mapping:** `in_port = {flag[3], flag[2], flag[1], flag[0], db[3], db[2], db[1], db[0]}`. `count_port` is the counter register. Both outputs are registered, with no combinational path from `btn` or `ack`.
- **Software handshake:**
  1. Program polls `port09` until bit 4+i is set.
  2. Program writes `port07` bit i = 1, then writes it back to 0.
  3. The flag is cleared while the bit is high.

## Timing
- **Reset values:** `s1`, `s2`, `db`, `cnt`, flags and counter are all 0, so `in_port` = 8'h00 and `count_port` = 8'h00. These hold from reset assertion, with no clock needed.
- **Debounce latency:**
  - Edge E0 is the first rising edge that samples a stable new pad level.
  - `s2` updates at E0+1.
  - Mismatch is counted at E0+2 … E0+DEBOUNCE_CYCLES+1.
  - `db`, and a press flag or counter increment, update at edge E0+DEBOUNCE_CYCLES+1.
  - With D=4: the new level is visible after the 6th edge counting E0 as the 1st.
- **Ack latency:** `ack[i]` sampled high at edge E clears the flag at E, visible after E. `ack[7]` behaves the same for the counter.
- **Glitch rejection:** a pad pulse that is stable for at most DEBOUNCE_CYCLES-1 sampling edges leaves `db` unchanged.
- **Reset mid-operation:** any partial debounce count, pending flag or count is lost. After release, a button already held down needs a full debounce and then produces a fresh press event.
- **Buttons are independent:** simultaneous events on several buttons all register in the same cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `clk` period 20 ns.
- **Reset:** pulse `reset` low mid-cycle while `btn` = 4'b0001 -> `in_port` = 8'h00 and `count_port` = 8'h00 immediately. After release with the button held, `in_port` = 8'h11 and `count_port` = 1 after 6 edges.
- **Clean press:** hold `btn[0]` = 1.
  - `in_port` stays 8'h00 for 5 edges, then becomes 8'h11 and `count_port` = 1.
  - Release, then wait 6 edges -> `in_port` = 8'h10.
- **Bounce:** toggle `btn[2]` with pulses 1, 2 and 3 cycles wide -> `in_port` stays 8'h00. Then hold 4+ cycles -> 8'h44 exactly once.
- **Ack and collision:**
  - After a button-1 event, set `ack` = 8'h02 for 1 cycle -> bit 5 clears.
  - A new press event landing on the same edge as `ack[1]` = 1 -> bit 5 stays 1.
- **Counter wrap and clear:**
  - 256 debounced presses on `btn[0]` -> `count_port` returns to 0.
  - `ack[7]` = 1 on the same edge as a press -> `count_port` = 1.
- **Simultaneous buttons:** `btn` = 4'b1111 held -> `in_port` goes from 8'h00 to 8'hFF on a single edge. `ack` = 8'h0F -> 8'h0F.
